// File: rtl/zero_second_ram_array.sv
// zero_second_ram_array
//   A DEPTH x DATA_WIDTH word array that is written and read through
//   asynchronous strobes. Each strobe passes through its own synchroniser
//   and rising-edge detector, and the resulting one-cycle pulse acts as
//   a command. Every word has a valid bit. A read and a write that hit
//   the same address in the same cycle return the write data. ClearAll
//   starts a sweep that clears one valid bit per cycle.
//
// Parameters
//   DATA_WIDTH   bits per word
//   ADDR_WIDTH   address bits; DEPTH = 2**ADDR_WIDTH
//   SYNC_STAGES  synchroniser flops per strobe (2 or more)
//
// Ports
//   Crystal50Mhz  in   clock, rising edge
//   ResetN        in   asynchronous active-low reset
//   WriteEdge     in   async write strobe; a rising edge is one write
//   WriteAddress  in   write address, held stable until WriteDone
//   inputData     in   write data, held stable until WriteDone
//   ReadEdge      in   async read strobe; a rising edge is one read
//   ReadAddress   in   read address, held stable until ReadDone
//   ClearAll      in   synchronous level; starts a clear sweep
//   outputData    out  registered read data; holds between reads
//   ReadHit       out  the word read had been written since reset/clear
//   ReadDone      out  1-cycle pulse when outputData/ReadHit update
//   WriteDone     out  1-cycle pulse when a write commits
//   Busy          out  high while the clear sweep runs
//   Dropped       out  1-cycle pulse when a strobe is discarded
module zero_second_ram_array #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  Crystal50Mhz,
    input  logic                  ResetN,
    input  logic                  WriteEdge,
    input  logic [ADDR_WIDTH-1:0] WriteAddress,
    input  logic [DATA_WIDTH-1:0] inputData,
    input  logic                  ReadEdge,
    input  logic [ADDR_WIDTH-1:0] ReadAddress,
    input  logic                  ClearAll,
    output logic [DATA_WIDTH-1:0] outputData,
    output logic                  ReadHit,
    output logic                  ReadDone,
    output logic                  WriteDone,
    output logic                  Busy,
    output logic                  Dropped
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_LANES = 2;  // lane 0 = write strobe, lane 1 = read strobe

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} stateT;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  hit;
    } rdRespT;

    // ------------------------------------------------------------------
    // Strobe synchronisers and rising-edge detectors, one per lane.
    // The edge detector's prev flop resets to 0, so a strobe that is
    // already high when reset releases still gives exactly one pulse.
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0] strobeIn;
    logic [NUM_LANES-1:0] pulse;

    assign strobeIn = {ReadEdge, WriteEdge};

    for (genvar l = 0; l < NUM_LANES; l++) begin : gSync
        logic [SYNC_STAGES-1:0] syncQ;
        logic                   prevQ;

        always_ff @(posedge Crystal50Mhz or negedge ResetN) begin
            if (!ResetN) begin
                syncQ <= '0;
                prevQ <= 1'b0;
            end else begin
                syncQ <= {syncQ[SYNC_STAGES-2:0], strobeIn[l]};
                prevQ <= syncQ[SYNC_STAGES-1];
            end
        end

        assign pulse[l] = syncQ[SYNC_STAGES-1] & ~prevQ;
    end

    logic wrPulse;
    logic rdPulse;
    assign wrPulse = pulse[0];
    assign rdPulse = pulse[1];

    // ------------------------------------------------------------------
    // IDLE/CLEAR FSM: state register, next-state logic, output decode
    // ------------------------------------------------------------------
    stateT                 state;
    stateT                 stateNext;
    logic [ADDR_WIDTH-1:0] sweepCnt;
    logic                  sweepLast;
    logic                  clearEn;
    logic                  acceptC;

    assign sweepLast = &sweepCnt;

    always_ff @(posedge Crystal50Mhz or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= stateNext;
    end

    // ClearAll still high on the last sweep word starts another sweep
    // straight away, with no IDLE cycle between the two.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (ClearAll)  stateNext = CLEAR;
            CLEAR:   if (sweepLast) stateNext = ClearAll ? CLEAR : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Strobes are accepted only in IDLE when no sweep is about to start.
    // This keeps writes from racing the sweep over the valid bits.
    always_comb begin
        clearEn = 1'b0;
        acceptC = 1'b0;
        case (state)
            IDLE:    acceptC = ~ClearAll;
            CLEAR:   clearEn = 1'b1;
            default: ;
        endcase
    end

    assign Busy = clearEn;

    // The sweep counter wraps to 0 on its last word. It is therefore
    // already 0 when the next sweep starts.
    always_ff @(posedge Crystal50Mhz or negedge ResetN) begin
        if (!ResetN)      sweepCnt <= '0;
        else if (clearEn) sweepCnt <= sweepCnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Storage. The data array has no reset; the valid bits decide
    // whether a stored word is visible.
    // ------------------------------------------------------------------
    logic                                 wrAcc;
    logic                                 rdAcc;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]     mem;
    logic [DEPTH-1:0]                     valid;

    assign wrAcc = wrPulse & acceptC;
    assign rdAcc = rdPulse & acceptC;

    always_ff @(posedge Crystal50Mhz) begin
        if (wrAcc) mem[WriteAddress] <= inputData;
    end

    // clearEn and wrAcc are never high together, so these updates never
    // target the same bit in the same cycle.
    always_ff @(posedge Crystal50Mhz or negedge ResetN) begin
        if (!ResetN) begin
            valid <= '0;
        end else begin
            if (clearEn) valid[sweepCnt]     <= 1'b0;
            if (wrAcc)   valid[WriteAddress] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read response and handshakes
    // ------------------------------------------------------------------
    rdRespT rdResp;
    rdRespT rdRespNext;

    // A write to the address being read in the same cycle takes priority
    // over the array contents (write-through).
    always_comb begin
        rdRespNext = rdResp;
        if (rdAcc) begin
            if (wrAcc && (WriteAddress == ReadAddress)) begin
                rdRespNext.data = inputData;
                rdRespNext.hit  = 1'b1;
            end else begin
                rdRespNext.data = valid[ReadAddress] ? mem[ReadAddress] : '0;
                rdRespNext.hit  = valid[ReadAddress];
            end
        end
    end

    always_ff @(posedge Crystal50Mhz or negedge ResetN) begin
        if (!ResetN) begin
            rdResp    <= '0;
            ReadDone  <= 1'b0;
            WriteDone <= 1'b0;
            Dropped   <= 1'b0;
        end else begin
            rdResp    <= rdRespNext;
            ReadDone  <= rdAcc;
            WriteDone <= wrAcc;
            // Read and write pulses discarded in the same cycle give a
            // single Dropped pulse.
            Dropped   <= (wrPulse | rdPulse) & ~acceptC;
        end
    end

    assign outputData = rdResp.data;
    assign ReadHit    = rdResp.hit;

endmodule
